// File: rtl/ups_pkg.sv
// Shared state encoding, lane layout and 2x2 block arithmetic for the bilinear upscaler.
// Build macro UPS_ROUND_EN: defined = round-half-up on TR/BL/BR, undefined = truncation.
package ups_pkg;

  typedef enum logic [1:0] {FILL, RUN, EOL, FLUSH} ups_state_e;

  localparam int PIX_W = 8;

  localparam int TL = 0;
  localparam int TR = 1;
  localparam int BL = 2;
  localparam int BR = 3;

`ifdef UPS_ROUND_EN
  localparam logic [PIX_W:0]   RND_HALF    = 9'd1;
  localparam logic [PIX_W+1:0] RND_QUARTER = 10'd2;
`else
  localparam logic [PIX_W:0]   RND_HALF    = 9'd0;
  localparam logic [PIX_W+1:0] RND_QUARTER = 10'd0;
`endif

  // Averages never exceed the largest input, so the narrowing casts cannot overflow.
  function automatic logic [4*PIX_W-1:0] bilin4(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b,
                                                input logic [PIX_W-1:0] c,
                                                input logic [PIX_W-1:0] d);
    logic [PIX_W:0]     tr_s;
    logic [PIX_W:0]     bl_s;
    logic [PIX_W+1:0]   br_s;
    logic [4*PIX_W-1:0] w;
    tr_s = {1'b0, a} + {1'b0, b} + RND_HALF;
    bl_s = {1'b0, a} + {1'b0, c} + RND_HALF;
    br_s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + RND_QUARTER;
    w = '0;
    w[TL*PIX_W +: PIX_W] = a;
    w[TR*PIX_W +: PIX_W] = PIX_W'(tr_s >> 1);
    w[BL*PIX_W +: PIX_W] = PIX_W'(bl_s >> 1);
    w[BR*PIX_W +: PIX_W] = PIX_W'(br_s >> 2);
    return w;
  endfunction

endpackage

// File: rtl/upsample_2x_bilinear_line_buffer.sv
// One-line pixel store: asynchronous read and synchronous write sharing a single address.
module line_buffer
  import ups_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/upsample_2x_bilinear.sv
// Streaming 2x bilinear upscaler: one 32-bit 2x2 block word per input pixel, raster order.
// Rounding of the interpolated lanes is selected by the UPS_ROUND_EN macro (see ups_pkg).
module upsample_2x_bilinear
  import ups_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int WO     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WO-1:0]    out_data,
  output logic             out_vld,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  ups_state_e       state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] a_q, a_d;
  logic [PIX_W-1:0] c_q, c_d;
  logic [WO-1:0]    out_data_q, out_data_d;
  logic             out_vld_q, out_vld_d;
  logic             frame_done_q, frame_done_d;

  logic [CW-1:0]    lb_addr;
  logic             lb_we;
  logic [PIX_W-1:0] lb_rdata;
  logic [PIX_W-1:0] flush_b;
  logic             xfer;

  line_buffer #(.DEPTH(WIDTH), .AW(CW)) u_lb (
    .clk   (clk),
    .addr  (lb_addr),
    .we    (lb_we),
    .wdata (in_pix),
    .rdata (lb_rdata)
  );

  assign in_rdy = (state_q == FILL) || (state_q == RUN);
  assign xfer   = in_vld && in_rdy;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    a_d          = a_q;
    c_d          = c_q;
    out_data_d   = out_data_q;
    out_vld_d    = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    lb_addr      = col_q;
    flush_b      = lb_rdata;
    case (state_q)
      FILL: begin
        if (xfer) begin
          lb_we = 1'b1;
          if (col_q == COL_LAST) begin
            state_d = RUN;
            col_d   = '0;
            row_d   = RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      RUN: begin
        // lb_rdata is still the previous row here; the write lands at the clock edge.
        if (xfer) begin
          lb_we = 1'b1;
          a_d   = lb_rdata;
          c_d   = in_pix;
          if (col_q != '0) begin
            out_vld_d  = 1'b1;
            out_data_d = bilin4(a_q, lb_rdata, c_q, in_pix);
          end
          if (col_q == COL_LAST) begin
            state_d = EOL;
            col_d   = '0;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      EOL: begin
        lb_addr    = '0;
        out_vld_d  = 1'b1;
        out_data_d = bilin4(a_q, a_q, c_q, c_q);
        if (row_q == ROW_LAST) begin
          state_d = FLUSH;
          a_d     = lb_rdata;
        end else begin
          state_d = RUN;
          row_d   = row_q + RW'(1);
        end
      end
      FLUSH: begin
        // a_q holds lb[col]; read one column ahead so the single read port suffices.
        if (col_q == COL_LAST) begin
          lb_addr = col_q;
          flush_b = a_q;
        end else begin
          lb_addr = col_q + CW'(1);
        end
        a_d        = lb_rdata;
        out_vld_d  = 1'b1;
        out_data_d = bilin4(a_q, flush_b, a_q, flush_b);
        if (col_q == COL_LAST) begin
          frame_done_d = 1'b1;
          state_d      = FILL;
          row_d        = '0;
          col_d        = '0;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      out_data_q   <= '0;
      out_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_data_q   <= out_data_d;
      out_vld_q    <= out_vld_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    c_q <= c_d;
  end

  assign out_data   = out_data_q;
  assign out_vld    = out_vld_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_upsample_2x_bilinear.sv
// Self-checking bench for upsample_2x_bilinear: three instances (4x2, 4x4, 128x128) against a pixel-level model.
module tb_upsample_2x_bilinear;

`ifdef UPS_ROUND_EN
  localparam int RH = 1;
  localparam int RQ = 2;
`else
  localparam int RH = 0;
  localparam int RQ = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  in_pix     [3];
  logic        in_vld     [3];
  logic        in_rdy     [3];
  logic [31:0] out_data   [3];
  logic        out_vld    [3];
  logic        frame_done [3];

  logic [31:0] got_q [3][$];
  logic [31:0] exp_q [$];
  int          fd_cnt    [3];
  int          fd_at     [3];
  int          stall_cnt [3];
  int          img [];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  upsample_2x_bilinear #(.WIDTH(4), .HEIGHT(2), .WO(32)) u_4x2 (
    .clk(clk), .rstn(rstn), .in_pix(in_pix[0]), .in_vld(in_vld[0]), .in_rdy(in_rdy[0]),
    .out_data(out_data[0]), .out_vld(out_vld[0]), .frame_done(frame_done[0]));

  upsample_2x_bilinear #(.WIDTH(4), .HEIGHT(4), .WO(32)) u_4x4 (
    .clk(clk), .rstn(rstn), .in_pix(in_pix[1]), .in_vld(in_vld[1]), .in_rdy(in_rdy[1]),
    .out_data(out_data[1]), .out_vld(out_vld[1]), .frame_done(frame_done[1]));

  upsample_2x_bilinear #(.WIDTH(128), .HEIGHT(128), .WO(32)) u_big (
    .clk(clk), .rstn(rstn), .in_pix(in_pix[2]), .in_vld(in_vld[2]), .in_rdy(in_rdy[2]),
    .out_data(out_data[2]), .out_vld(out_vld[2]), .frame_done(frame_done[2]));

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (out_vld[k] === 1'b1) got_q[k].push_back(out_data[k]);
      if (frame_done[k] === 1'b1) begin
        fd_cnt[k]++;
        fd_at[k] = got_q[k].size();
      end
      if (rstn === 1'b1 && in_rdy[k] === 1'b0) stall_cnt[k]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] blk(input int a, input int b, input int c, input int d);
    int tr, bl, br;
    tr = (a + b + RH) / 2;
    bl = (a + c + RH) / 2;
    br = (a + b + c + d + RQ) / 4;
    return {br[7:0], bl[7:0], tr[7:0], a[7:0]};
  endfunction

  // Every output pixel of block (r,c) interpolates toward the right and lower neighbours, edges clamped.
  function automatic void build_model(input int w, input int h);
    int rn, cn;
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        rn = (r + 1 < h) ? r + 1 : r;
        cn = (c + 1 < w) ? c + 1 : c;
        exp_q.push_back(blk(img[r*w+c], img[r*w+cn], img[rn*w+c], img[rn*w+cn]));
      end
    end
  endfunction

  task automatic drive_frame(input int k, input int n, input int vld_pct, input int budget);
    int idx, cyc;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (int'($urandom_range(99)) < vld_pct) begin
        in_vld[k] = 1'b1;
        in_pix[k] = img[idx][7:0];
        if (in_rdy[k] === 1'b1) idx++;
      end else begin
        in_vld[k] = 1'b0;
      end
    end
    @(negedge clk);
    in_vld[k] = 1'b0;
    check("drive_accepted", idx, n);
  endtask

  task automatic wait_words(input int k, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (got_q[k].size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("word_count", got_q[k].size(), n);
  endtask

  task automatic compare_frame(input int k, input int base, input string tag);
    for (int i = 0; i < exp_q.size(); i++) check(tag, got_q[k][base+i], exp_q[i]);
  endtask

  initial begin
    int base, fd0, bad, first_bad;
    logic [31:0] w, single_exp;

    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_vld[k] = 1'b0;
      in_pix[k] = 8'd0;
      fd_cnt[k] = 0;
      fd_at[k] = 0;
      stall_cnt[k] = 0;
    end
    #1 rstn = 1'b0;
    #2;
    check("rst_out_vld", out_vld[0], 0);
    check("rst_out_data", out_data[0], 0);
    check("rst_frame_done", frame_done[0], 0);
    check("rst_in_rdy", in_rdy[0], 1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Flat grey 4x2 frame
    img = new[8];
    foreach (img[i]) img[i] = 100;
    build_model(4, 2);
    stall_cnt[0] = 0;
    drive_frame(0, 8, 100, 200);
    wait_words(0, 8, 50);
    compare_frame(0, 0, "flat_word");
    check("flat_first_const", got_q[0][0], 32'h6464_6464);
    check("flat_last_const", got_q[0][7], 32'h6464_6464);
    check("flat_fd_count", fd_cnt[0], 1);
    check("flat_fd_position", fd_at[0], 8);
    check("flat_stall_cycles", stall_cnt[0], 5);

    // Horizontal ramp 0,10,20,30 on both rows
    base = got_q[0].size();
    foreach (img[i]) img[i] = (i % 4) * 10;
    build_model(4, 2);
    drive_frame(0, 8, 100, 200);
    wait_words(0, base + 8, 50);
    compare_frame(0, base, "ramp_word");
    check("ramp_word00_const", got_q[0][base], 32'h0500_0500);
    check("ramp_word03_const", got_q[0][base+3], 32'h1E1E_1E1E);
    check("ramp_fd_count", fd_cnt[0], 2);

    // Single nonzero B sample at block (0,0)
    base = got_q[0].size();
    foreach (img[i]) img[i] = 0;
    img[1] = 1;
    build_model(4, 2);
`ifdef UPS_ROUND_EN
    single_exp = 32'h0000_0100;
`else
    single_exp = 32'h0000_0000;
`endif
    drive_frame(0, 8, 100, 200);
    wait_words(0, base + 8, 50);
    check("single_b_word00", got_q[0][base], single_exp);
    compare_frame(0, base, "single_b_word");

    // 4x4 ramp: right-edge and bottom-edge clamping
    img = new[16];
    foreach (img[i]) img[i] = (i / 4) * 40 + (i % 4) * 13;
    build_model(4, 4);
    drive_frame(1, 16, 100, 300);
    wait_words(1, 16, 50);
    compare_frame(1, 0, "ramp4x4_word");
    w = got_q[1][3];
    check("edge_tr_eq_tl", w[15:8], img[3]);
    check("edge_br_eq_bl", w[31:24], (img[3] + img[7] + RH) / 2);
    for (int c = 0; c < 4; c++) begin
      w = got_q[1][12+c];
      check("lastrow_bl_eq_tl", w[23:16], img[12+c]);
    end
    check("ramp4x4_fd_count", fd_cnt[1], 1);

    // 128x128 random frame with random input gaps
    img = new[128*128];
    foreach (img[i]) img[i] = int'($urandom_range(255));
    build_model(128, 128);
    stall_cnt[2] = 0;
    drive_frame(2, 128*128, 60, 60000);
    wait_words(2, 128*128, 400);
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_q[2][i] !== exp_q[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    check("big_bad_words", bad, 0);
    if (first_bad >= 0) check("big_first_bad_word", got_q[2][first_bad], exp_q[first_bad]);
    check("big_fd_count", fd_cnt[2], 1);
    check("big_fd_position", fd_at[2], 128*128);
    check("big_stall_cycles", stall_cnt[2], 127 + 128);

    // Back-to-back 4x2 frames, reset during the second frame's row 1
    img = new[8];
    foreach (img[i]) img[i] = int'($urandom_range(255));
    build_model(4, 2);
    base = got_q[0].size();
    fd0 = fd_cnt[0];
    drive_frame(0, 8, 100, 200);
    drive_frame(0, 6, 100, 200);
    in_vld[0] = 1'b1;
    in_pix[0] = img[6][7:0];
    @(posedge clk);
    #2;
    check("midrst_pre_vld", out_vld[0], 1);
    in_vld[0] = 1'b0;
    rstn = 1'b0;
    #1;
    check("midrst_out_vld", out_vld[0], 0);
    check("midrst_out_data", out_data[0], 0);
    check("midrst_in_rdy", in_rdy[0], 1);
    repeat (3) @(negedge clk);
    check("midrst_word_count", got_q[0].size(), base + 8 + 1);
    check("midrst_fd_count", fd_cnt[0], fd0 + 1);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_more_words", got_q[0].size(), base + 8 + 1);
    compare_frame(0, base, "b2b_frame1_word");

    base = got_q[0].size();
    foreach (img[i]) img[i] = int'($urandom_range(255));
    build_model(4, 2);
    drive_frame(0, 8, 100, 200);
    wait_words(0, base + 8, 50);
    compare_frame(0, base, "post_rst_word");
    check("post_rst_fd_count", fd_cnt[0], fd0 + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/upsample_2x_bilinear.md
Name: upsample_2x_bilinear

Overview:
- Streaming 2x bilinear upscaler that sits directly upstream of the 2x BMP writer.
- Accepts an 8-bit grayscale raster of WIDTH x HEIGHT pixels.
- For each input pixel (r,c) it emits one 32-bit word carrying the 2x2 output block, in the byte order the writer expects.
- Uses a single-line buffer, an input valid/ready handshake, and a registered output valid with no backpressure.

Parameters:
- WIDTH, 128, input line length in pixels; must be >= 2.
- HEIGHT, 128, input line count; must be >= 2.
- WO, 32, output word width; fixed at 4 x 8.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_pix  in  8  input pixel, raster order
- in_vld  in  1  input pixel valid
- in_rdy  out  1  block can accept a pixel; transfer occurs when in_vld && in_rdy
- out_data  out  WO  block word: [7:0]=top-left, [15:8]=top-right, [23:16]=bottom-left, [31:24]=bottom-right
- out_vld  out  1  out_data valid for one cycle; downstream must always accept
- frame_done  out  1  one-cycle pulse coincident with the last out_vld of a frame

Behaviour:
- Reset: clk is the clock; rstn is asynchronous and active-low.
  - out_vld=0, out_data=0, frame_done=0, in_rdy=1.
  - State=FILL; col=0, row=0.
  - Line buffer contents are don't-care.
- Sample naming for block (r,c):
  - A=in(r,c), B=in(r,c+1), C=in(r+1,c), D=in(r+1,c+1).
  - Clamp at edges: column WIDTH-1 uses B=A and D=C; row HEIGHT-1 uses C=A and D=B.
- Block arithmetic (9/10-bit intermediate sums, result 8-bit, never saturates):
  - TL = A
  - TR = (A+B+1)>>1
  - BL = (A+C+1)>>1
  - BR = (A+B+C+D+2)>>2
- FILL (row 0):
  - Each accepted pixel is written to lb[col]; no output.
  - After col=WIDTH-1 → RUN, row=1.
- RUN (rows 1..HEIGHT-1), per accepted pixel at col c:
  - Read lb[c] (old row) and write in_pix to lb[c] in the same cycle; read-before-write.
  - Registers a_q = previous lb read and c_q = previous in_pix.
  - For c >= 1: emit block (row-1, c-1) with A=a_q, B=lb[c], C=c_q, D=in_pix.
  - After c=WIDTH-1 → EOL.
- EOL:
  - in_rdy=0 for exactly one cycle.
  - Emit block (row-1, WIDTH-1) with B=A, D=C.
  - If row==HEIGHT-1 → FLUSH; else row+1 → RUN.
- FLUSH:
  - in_rdy=0 for WIDTH cycles.
  - Emit blocks (HEIGHT-1, 0..WIDTH-1) from lb with C=A, D=B; the last column also clamps B=A.
  - frame_done pulses with the final word; then → FILL, row=0, col=0.
- Latency: out_vld asserts the cycle after the transfer/state cycle that produces the word (registered output).
- Per-frame totals:
  - Exactly WIDTH*HEIGHT output words per frame.
  - Output order is raster over (r,c).
  - Input stall cycles = HEIGHT-1 + WIDTH.
- in_vld low: no state change; internal registers hold; no output in RUN/FILL.
  - EOL and FLUSH proceed regardless of in_vld.
- Back-to-back frames: first pixel of the next frame is accepted the cycle after FLUSH ends.
- Reset mid-frame: immediately return to the reset state; partial frame discarded; no frame_done.

Optional Feature:
- Macro: UPS_ROUND_EN.
- Defined: rounding constants +1 (TR, BL) and +2 (BR) are applied, as specified above.
- Undefined: the rounding constants are omitted (truncation).
- TL is unaffected in both cases.

Decomposition:
- Shared package `ups_pkg` holds:
  - state enum {FILL, RUN, EOL, FLUSH};
  - PIX_W=8;
  - byte-lane index constants TL/TR/BL/BR;
  - the function bilin4(A,B,C,D) returning the packed 32-bit word.
- One sub-module, `line_buffer`: WIDTH x 8 array with async read and sync write on the same address.

Test Plan:
- WIDTH=4, HEIGHT=2, every pixel 100 → 8 words of 0x64646464; frame_done on the 8th word; in_rdy low 1+4 cycles.
- WIDTH=4, HEIGHT=2, both rows 0,10,20,30 (UPS_ROUND_EN) → word(0,0)=0x05000500; word(0,3)=0x1E1E1E1E.
- Single nonzero B=1, others 0, at block (0,0):
  - UPS_ROUND_EN defined → TR=1, BR=0, word=0x00000100.
  - Undefined → word=0x00000000.
- in_vld toggled 1-0-1 randomly over 128x128 → 16384 words, identical to the gap-free run; frame_done exactly once.
- Two consecutive 4x2 frames, with rstn pulsed low during the second frame's row 1 → outputs stop immediately; a fresh frame afterwards matches the golden model.
- Row-edge check: block (0,3) in a 4x4 ramp → TR=TL and BR=BL (clamp); the last row's blocks have BL=TL.
